// File: rtl/bgpu_pkg.sv
// -----------------------------------------------------------------------------
// bgpu_pkg
// Shared definitions for the compute-unit front end.
//   warp_state_e : per-warp fetch state (IDLE, READY, WAIT_DEC)
//   NUM_WARPS, WARP_WIDTH, PC_WIDTH : default widths used by the fetch stage
// -----------------------------------------------------------------------------
package bgpu_pkg;

    localparam int unsigned NUM_WARPS  = 8;
    localparam int unsigned WARP_WIDTH = 32;
    localparam int unsigned PC_WIDTH   = 32;

    typedef enum logic [1:0] {
        WARP_IDLE     = 2'd0,
        WARP_READY    = 2'd1,
        WARP_WAIT_DEC = 2'd2
    } warp_state_e;

endpackage

// File: rtl/rr_warp_selector.sv
// -----------------------------------------------------------------------------
// rr_warp_selector
// Round-robin pick of one warp out of an eligibility mask. The search starts
// one past the last granted warp and wraps; the pointer only moves when the
// caller actually takes the grant.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   eligible_i     : per-warp eligibility
//   advance_i      : grant is consumed this cycle, move the pointer
//   gnt_valid_o    : at least one warp eligible
//   gnt_idx_o      : chosen warp
// -----------------------------------------------------------------------------
module rr_warp_selector #(
    parameter int unsigned NumWarps = 8,
    parameter int unsigned WidWidth = $clog2(NumWarps)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumWarps-1:0] eligible_i,
    input  logic                advance_i,
    output logic                gnt_valid_o,
    output logic [WidWidth-1:0] gnt_idx_o
);

    logic [WidWidth-1:0] ptr_reg;

    // Reset to the last warp so that warp 0 is the first candidate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= WidWidth'(NumWarps - 1);
        end else if (advance_i && gnt_valid_o) begin
            ptr_reg <= gnt_idx_o;
        end
    end

    // Walk candidates from farthest to nearest so the nearest eligible warp
    // after the pointer is the last one written and therefore wins.
    always_comb begin
        int idx;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        for (int k = int'(NumWarps); k >= 1; k--) begin
            idx = (int'(ptr_reg) + k) % int'(NumWarps);
            if (eligible_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = WidWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/fetcher.sv
// -----------------------------------------------------------------------------
// fetcher
// Fetch stage: per-warp pc / active mask / state, round-robin warp pick and a
// registered request to the instruction cache. One instruction per warp in
// flight; decode returns the next pc (or a stop) before the warp refetches.
// Optional build macro: BGPU_FETCHER_STALL_COUNT_EN adds a saturating count of
// cycles with a request held back by the cache; otherwise stall_cycles_o = 0.
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   init_*                        : start an IDLE warp with pc and mask
//   ib_space_i                    : per-warp instruction buffer has room
//   ic_ready_i, fe_*              : request to the instruction cache
//   dec_*                         : decode feedback (next pc or stop)
//   warp_idle_o                   : per-warp IDLE flag
//   stall_cycles_o                : cache backpressure cycle count
// -----------------------------------------------------------------------------
module fetcher
    import bgpu_pkg::*;
#(
    parameter int unsigned NumWarps  = NUM_WARPS,
    parameter int unsigned WarpWidth = WARP_WIDTH,
    parameter int unsigned PcWidth   = PC_WIDTH,
    parameter int unsigned WidWidth  = $clog2(NumWarps)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 init_ready_o,
    input  logic                 init_valid_i,
    input  logic [WidWidth-1:0]  init_warp_id_i,
    input  logic [PcWidth-1:0]   init_pc_i,
    input  logic [WarpWidth-1:0] init_act_mask_i,
    input  logic [NumWarps-1:0]  ib_space_i,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 dec_valid_i,
    input  logic [WidWidth-1:0]  dec_warp_id_i,
    input  logic [PcWidth-1:0]   dec_next_pc_i,
    input  logic                 dec_stop_i,
    output logic [NumWarps-1:0]  warp_idle_o,
    output logic [31:0]          stall_cycles_o
);

    warp_state_e          state_arr [NumWarps];
    logic [PcWidth-1:0]   pc_arr    [NumWarps];
    logic [WarpWidth-1:0] mask_arr  [NumWarps];
    logic [NumWarps-1:0]  eligible;

    logic                 gnt_valid;
    logic [WidWidth-1:0]  gnt_idx;
    logic                 out_free;
    logic                 load;

    logic                 fe_valid_reg;
    logic [PcWidth-1:0]   fe_pc_reg;
    logic [WarpWidth-1:0] fe_act_mask_reg;
    logic [WidWidth-1:0]  fe_warp_id_reg;

    // The output register can take a new request when empty or being drained.
    assign out_free = !fe_valid_reg || ic_ready_i;
    assign load     = out_free && gnt_valid;

    rr_warp_selector #(
        .NumWarps (NumWarps),
        .WidWidth (WidWidth)
    ) u_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .eligible_i  (eligible),
        .advance_i   (out_free),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Per-warp context. Init, grant and feedback each require a distinct
    // current state, so at most one of them can act on a warp per cycle.
    generate
        for (genvar gi = 0; gi < int'(NumWarps); gi++) begin : g_warp
            warp_state_e          state_reg, state_next;
            logic [PcWidth-1:0]   pc_reg, pc_next;
            logic [WarpWidth-1:0] mask_reg, mask_next;
            logic                 init_hit, gnt_hit, dec_hit;

            assign init_hit = init_valid_i && (init_warp_id_i == WidWidth'(gi));
            assign gnt_hit  = load && (gnt_idx == WidWidth'(gi));
            assign dec_hit  = dec_valid_i && (dec_warp_id_i == WidWidth'(gi));

            always_comb begin
                state_next = state_reg;
                pc_next    = pc_reg;
                mask_next  = mask_reg;
                case (state_reg)
                    WARP_IDLE: begin
                        if (init_hit) begin
                            state_next = WARP_READY;
                            pc_next    = init_pc_i;
                            mask_next  = init_act_mask_i;
                        end
                    end
                    WARP_READY: begin
                        if (gnt_hit) begin
                            state_next = WARP_WAIT_DEC;
                        end
                    end
                    WARP_WAIT_DEC: begin
                        if (dec_hit) begin
                            if (dec_stop_i) begin
                                state_next = WARP_IDLE;
                            end else begin
                                state_next = WARP_READY;
                                pc_next    = dec_next_pc_i;
                            end
                        end
                    end
                    default: state_next = WARP_IDLE;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg <= WARP_IDLE;
                    pc_reg    <= '0;
                    mask_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    pc_reg    <= pc_next;
                    mask_reg  <= mask_next;
                end
            end

            assign state_arr[gi]   = state_reg;
            assign pc_arr[gi]      = pc_reg;
            assign mask_arr[gi]    = mask_reg;
            assign eligible[gi]    = (state_reg == WARP_READY) && ib_space_i[gi];
            assign warp_idle_o[gi] = (state_reg == WARP_IDLE);
        end
    endgenerate

    assign init_ready_o = (state_arr[init_warp_id_i] == WARP_IDLE);

    // Request register: fields only change on a load, so they stay stable
    // while the cache is backpressuring.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fe_valid_reg    <= 1'b0;
            fe_pc_reg       <= '0;
            fe_act_mask_reg <= '0;
            fe_warp_id_reg  <= '0;
        end else if (load) begin
            fe_valid_reg    <= 1'b1;
            fe_pc_reg       <= pc_arr[gnt_idx];
            fe_act_mask_reg <= mask_arr[gnt_idx];
            fe_warp_id_reg  <= gnt_idx;
        end else if (ic_ready_i) begin
            fe_valid_reg    <= 1'b0;
        end
    end

    assign fe_valid_o    = fe_valid_reg;
    assign fe_pc_o       = fe_pc_reg;
    assign fe_act_mask_o = fe_act_mask_reg;
    assign fe_warp_id_o  = fe_warp_id_reg;

`ifdef BGPU_FETCHER_STALL_COUNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (fe_valid_reg && !ic_ready_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetcher.sv
module tb_fetcher;

    localparam int NW = 8;
    localparam int WW = 32;
    localparam int PW = 32;
    localparam int IW = 3;

    localparam int S_IDLE = 0;
    localparam int S_RDY  = 1;
    localparam int S_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          init_ready_o;
    logic          init_valid_i = 1'b0;
    logic [IW-1:0] init_warp_id_i = '0;
    logic [PW-1:0] init_pc_i = '0;
    logic [WW-1:0] init_act_mask_i = '0;
    logic [NW-1:0] ib_space_i = '1;
    logic          ic_ready_i = 1'b1;
    logic          fe_valid_o;
    logic [PW-1:0] fe_pc_o;
    logic [WW-1:0] fe_act_mask_o;
    logic [IW-1:0] fe_warp_id_o;
    logic          dec_valid_i = 1'b0;
    logic [IW-1:0] dec_warp_id_i = '0;
    logic [PW-1:0] dec_next_pc_i = '0;
    logic          dec_stop_i = 1'b0;
    logic [NW-1:0] warp_idle_o;
    logic [31:0]   stall_cycles_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetcher #(
        .NumWarps  (NW),
        .WarpWidth (WW),
        .PcWidth   (PW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .init_ready_o    (init_ready_o),
        .init_valid_i    (init_valid_i),
        .init_warp_id_i  (init_warp_id_i),
        .init_pc_i       (init_pc_i),
        .init_act_mask_i (init_act_mask_i),
        .ib_space_i      (ib_space_i),
        .ic_ready_i      (ic_ready_i),
        .fe_valid_o      (fe_valid_o),
        .fe_pc_o         (fe_pc_o),
        .fe_act_mask_o   (fe_act_mask_o),
        .fe_warp_id_o    (fe_warp_id_o),
        .dec_valid_i     (dec_valid_i),
        .dec_warp_id_i   (dec_warp_id_i),
        .dec_next_pc_i   (dec_next_pc_i),
        .dec_stop_i      (dec_stop_i),
        .warp_idle_o     (warp_idle_o),
        .stall_cycles_o  (stall_cycles_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: warp table plus the request the cache should see.
    // ---------------------------------------------------------------------
    int            m_st   [NW];
    logic [PW-1:0] m_pc   [NW];
    logic [WW-1:0] m_mask [NW];
    int            m_last;
    logic          m_v;
    logic [PW-1:0] m_fpc;
    logic [WW-1:0] m_fmask;
    logic [IW-1:0] m_fwid;
    longint        m_stall;
    bit            m_live = 1'b0;

    // Inputs change just after the rising edge, so at the falling edge they
    // already hold what the next rising edge will sample: compare first,
    // then advance the model by one clock.
    initial begin
        int            nst [NW];
        int            g;
        int            w;
        logic [NW-1:0] exp_idle;
        longint        exp_stall;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("fe_valid", fe_valid_o, m_v);
                check("fe_pc", fe_pc_o, m_fpc);
                check("fe_mask", fe_act_mask_o, m_fmask);
                check("fe_wid", fe_warp_id_o, m_fwid);
                for (int i = 0; i < NW; i++) exp_idle[i] = (m_st[i] == S_IDLE);
                check("warp_idle", warp_idle_o, exp_idle);
                check("init_ready", init_ready_o, m_st[init_warp_id_i] == S_IDLE);
`ifdef BGPU_FETCHER_STALL_COUNT_EN
                exp_stall = m_stall;
`else
                exp_stall = 0;
`endif
                check("stall_cycles", stall_cycles_o, exp_stall);
            end
            if (rst_i) begin
                for (int i = 0; i < NW; i++) begin
                    m_st[i] = S_IDLE; m_pc[i] = '0; m_mask[i] = '0;
                end
                m_last = NW - 1; m_v = 1'b0; m_fpc = '0; m_fmask = '0; m_fwid = '0;
                m_stall = 0; m_live = 1'b1;
            end else if (m_live) begin
                nst = m_st;
                if (m_v && !ic_ready_i && m_stall < 64'hFFFF_FFFF) m_stall++;
                g = -1;
                if (!m_v || ic_ready_i) begin
                    for (int k = 1; k <= NW; k++) begin
                        w = (m_last + k) % NW;
                        if (g < 0 && m_st[w] == S_RDY && ib_space_i[w]) g = w;
                    end
                end
                if (g >= 0) begin
                    m_v = 1'b1; m_fpc = m_pc[g]; m_fmask = m_mask[g]; m_fwid = IW'(g);
                    m_last = g; nst[g] = S_WAIT;
                end else if (ic_ready_i) begin
                    m_v = 1'b0;
                end
                if (init_valid_i && m_st[init_warp_id_i] == S_IDLE) begin
                    nst[init_warp_id_i]    = S_RDY;
                    m_pc[init_warp_id_i]   = init_pc_i;
                    m_mask[init_warp_id_i] = init_act_mask_i;
                end
                if (dec_valid_i && m_st[dec_warp_id_i] == S_WAIT) begin
                    if (dec_stop_i) begin
                        nst[dec_warp_id_i] = S_IDLE;
                    end else begin
                        nst[dec_warp_id_i]  = S_RDY;
                        m_pc[dec_warp_id_i] = dec_next_pc_i;
                    end
                end
                m_st = nst;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations.
    // ---------------------------------------------------------------------
    initial begin
        logic [IW-1:0] t2_wid [6];
        logic [PW-1:0] t2_pc  [6];
        logic [31:0]   exp_stall5;
        t2_wid = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        t2_pc  = '{32'h100, 32'h200, 32'h14, 32'h104, 32'h204, 32'h18};
`ifdef BGPU_FETCHER_STALL_COUNT_EN
        exp_stall5 = 32'd5;
`else
        exp_stall5 = 32'd0;
`endif

        // Reset state
        step(); step();
        check("rst_fe_valid", fe_valid_o, 1'b0);
        check("rst_fe_pc", fe_pc_o, 32'h0);
        check("rst_idle", warp_idle_o, 8'hFF);
        check("rst_stall", stall_cycles_o, 32'h0);
        check("rst_init_ready", init_ready_o, 1'b1);
        rst_i = 1'b0;

        // Single warp: two edges from init to request, then silence
        init_valid_i = 1'b1; init_warp_id_i = 3'd0; init_pc_i = 32'h10; init_act_mask_i = 32'hFFFF_FFFF;
        step();
        init_valid_i = 1'b0;
        check("t1_early", fe_valid_o, 1'b0);
        step();
        check("t1_valid", fe_valid_o, 1'b1);
        check("t1_pc", fe_pc_o, 32'h10);
        check("t1_wid", fe_warp_id_o, 3'd0);
        check("t1_mask", fe_act_mask_o, 32'hFFFF_FFFF);
        repeat (3) begin
            step();
            check("t1_no_refetch", fe_valid_o, 1'b0);
        end

        // Three warps round-robin; init and feedback share a cycle
        init_valid_i = 1'b1; init_warp_id_i = 3'd1; init_pc_i = 32'h100;
        dec_valid_i = 1'b1; dec_warp_id_i = 3'd0; dec_next_pc_i = 32'h14; dec_stop_i = 1'b0;
        step();
        dec_valid_i = 1'b0;
        init_warp_id_i = 3'd2; init_pc_i = 32'h200;
        step();
        init_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t2_valid", fe_valid_o, 1'b1);
            check("t2_wid", fe_warp_id_o, t2_wid[i]);
            check("t2_pc", fe_pc_o, t2_pc[i]);
            if (i < 5) begin
                dec_valid_i = fe_valid_o; dec_warp_id_i = fe_warp_id_o; dec_next_pc_i = fe_pc_o + 32'd4;
                step();
                dec_valid_i = 1'b0;
            end
        end

        // Cache backpressure: request holds, stall counter advances
        ic_ready_i = 1'b0;
        repeat (5) begin
            step();
            check("t3_hold_valid", fe_valid_o, 1'b1);
            check("t3_hold_wid", fe_warp_id_o, 3'd0);
            check("t3_hold_pc", fe_pc_o, 32'h18);
        end
        check("t3_stall", stall_cycles_o, exp_stall5);
        ic_ready_i = 1'b1;

        // No instruction-buffer space: warp 3 waits until its bit rises
        ib_space_i = 8'h00;
        init_valid_i = 1'b1; init_warp_id_i = 3'd3; init_pc_i = 32'h300; init_act_mask_i = 32'h0000_00FF;
        step();
        init_valid_i = 1'b0;
        repeat (5) begin
            check("t4_blocked", fe_valid_o, 1'b0);
            step();
        end
        check("t4_blocked_last", fe_valid_o, 1'b0);
        ib_space_i = 8'h08;
        step();
        check("t4_wid", fe_warp_id_o, 3'd3);
        check("t4_pc", fe_pc_o, 32'h300);
        ib_space_i = 8'hFF;

        // Stop warp 1, then restart it elsewhere
        step();
        check("t5_w1_wid", fe_warp_id_o, 3'd1);
        check("t5_w1_pc", fe_pc_o, 32'h108);
        step();
        check("t5_w2_wid", fe_warp_id_o, 3'd2);
        dec_valid_i = 1'b1; dec_warp_id_i = 3'd1; dec_stop_i = 1'b1; dec_next_pc_i = 32'hDEAD;
        init_warp_id_i = 3'd1;
        step();
        dec_valid_i = 1'b0; dec_stop_i = 1'b0;
        check("t5_idle1", warp_idle_o[1], 1'b1);
        check("t5_ready1", init_ready_o, 1'b1);
        init_valid_i = 1'b1; init_pc_i = 32'h40; init_act_mask_i = 32'h0000_000F;
        step();
        init_valid_i = 1'b0;
        step();
        check("t5_refetch_wid", fe_warp_id_o, 3'd1);
        check("t5_refetch_pc", fe_pc_o, 32'h40);
        check("t5_refetch_mask", fe_act_mask_o, 32'h0000_000F);

        // Init to a running warp is ignored
        ib_space_i = 8'hFB;
        dec_valid_i = 1'b1; dec_warp_id_i = 3'd2; dec_next_pc_i = 32'h20C;
        step();
        dec_valid_i = 1'b0;
        init_valid_i = 1'b1; init_warp_id_i = 3'd2; init_pc_i = 32'h99;
        step();
        init_valid_i = 1'b0;
        check("t6_not_ready", init_ready_o, 1'b0);
        ib_space_i = 8'hFF;
        step();
        check("t6_wid", fe_warp_id_o, 3'd2);
        check("t6_pc", fe_pc_o, 32'h20C);

        // Reset with a held request
        ic_ready_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        check("t7_valid", fe_valid_o, 1'b0);
        check("t7_idle", warp_idle_o, 8'hFF);
        rst_i = 1'b0;
        ic_ready_i = 1'b1;

        // Pointer restarts at warp 0 after reset
        ib_space_i = 8'h00;
        init_valid_i = 1'b1; init_warp_id_i = 3'd5; init_pc_i = 32'h500;
        step();
        init_warp_id_i = 3'd0; init_pc_i = 32'h80;
        step();
        init_valid_i = 1'b0;
        ib_space_i = 8'hFF;
        step();
        check("t8_first_wid", fe_warp_id_o, 3'd0);
        check("t8_first_pc", fe_pc_o, 32'h80);
        step();
        check("t8_second_wid", fe_warp_id_o, 3'd5);
        check("t8_second_pc", fe_pc_o, 32'h500);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
